multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control unit for the multi-cycle RV32I core. A Moore state machine sequences one instruction across 3–5 clock cycles. In each state it drives the select lines of the datapath's 2:1 and 3:1 multiplexers, the ALU operation, the immediate format and all architectural write enables. It sits beside the datapath and takes only the instruction fields and the ALU zero flag as inputs.

## Interface
- No parameters. The RV32I opcode encoding is fixed.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU result == 0.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALU result register.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register and old-PC register enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux: 00 = ALU output register, 01 = memory data register, 10 = live ALU result.
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1 register.
- alu_src_b  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4.
- imm_src  out  2  00 = I-type, 01 = S-type, 10 = B-type, 11 = J-type.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- state  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are unreachable and go to FETCH on the next edge.
- Transitions out of DECODE:
  - op 0000011 (lw) or 0100011 (sw) → MEMADR.
  - op 0110011 → EXECUTER.
  - op 0010011 → EXECUTEI.
  - op 1100011 → BEQ.
  - op 1101111 → JAL.
  - Any other op → FETCH (illegal opcode is treated as a no-op).
- Other transitions:
  - FETCH → DECODE.
  - MEMADR → MEMREAD for lw; MEMADR → MEMWRITE for sw. The decision uses op[5].
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
  - JAL → ALUWB.
  - ALUWB → FETCH.
  - BEQ → FETCH.
- Per-state outputs. Any output not listed is 0, except imm_src, which is always decoded from op.
  - FETCH: ir_write=1, pc_update=1, alu_src_b=10, result_src=10, alu_op=00.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. This computes the branch target.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, pc_update=1.
- pc_write = pc_update | (branch & zero).
- ALU decoder:
  - alu_op 00 → 000.
  - alu_op 01 → 001.
  - alu_op 10 → by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000.
    - 010 → 101.
    - 110 → 011.
    - 111 → 010.
    - any other value → 000.
- imm_src from op:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - all others → 00.

## Timing
- The state register updates on the rising edge of clk. All outputs are combinational from the registered state and the current inputs; there are no output registers.
- Instruction latency, counted from entering FETCH to re-entering FETCH:
  - lw: 5 cycles.
  - sw, R-type, I-type ALU, jal: 4 cycles each.
  - beq: 3 cycles.
  - illegal opcode: 2 cycles.
- op, funct3 and funct7b5 must be stable from the DECODE cycle through the end of the instruction. The instruction register is loaded only in FETCH, which guarantees this.
- zero is sampled only in BEQ, within the same cycle.
- Reset:
  - Assertion takes effect immediately, independent of clk; state becomes 0.
  - While reset=1, pc_write, ir_write, reg_write and mem_write are forced to 0.
  - The other outputs show FETCH values while reset=1: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_control=000.
  - After reset deasserts, the first rising edge moves FETCH → DECODE, with ir_write=1 and pc_write=1 asserted during that cycle.
  - Reset mid-instruction abandons the instruction. No write enable may pulse after reset asserts.

## Test plan
- Reset pulse during MEMWRITE of a sw: mem_write drops to 0 in the same cycle; state=0. After release, the first cycle shows ir_write=1 and pc_write=1, then state=1.
- lw (op=0000011): state sequence 0,1,2,3,4,0. reg_write=1 only in state 4, with result_src=01. adr_src=1 in state 3.
- R-type sub (op=0110011, funct3=000, funct7b5=1): alu_control=001 in EXECUTER. Same instruction with funct7b5=0 gives 000. I-type addi (op=0010011) with funct7b5=1 still gives 000.
- beq with zero=1: sequence 0,1,9,0, and pc_write=1 in state 9. With zero=0, pc_write=0 in state 9.
- jal (op=1101111): sequence 0,1,10,8,0. imm_src=11. pc_write=1 in state 10. reg_write=1 in state 8.
- Illegal opcode 0000000: sequence 0,1,0, and reg_write, mem_write and pc_write all stay 0 outside FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core: sequences one instruction
// over 3-5 cycles and drives datapath mux selects, ALU control and write enables.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4
  // DECODE   | read registers, compute branch target
  // MEMADR   | compute load/store address
  // MEMREAD  | read data memory
  // MEMWB    | write loaded data to register file
  // MEMWRITE | write store data to memory
  // EXECUTER | register-register ALU operation
  // EXECUTEI | register-immediate ALU operation
  // ALUWB    | write ALU result to register file
  // BEQ      | compare and conditionally take branch
  // JAL      | PC <= target, compute link address
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     cur, nxt;
  logic       pc_update, branch, ir_en, reg_en, mem_en;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt        = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    reg_en     = 1'b0;
    mem_en     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur)
      FETCH: begin
        nxt       = DECODE;
        ir_en     = 1'b1;
        pc_update = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_BEQ:       nxt = BEQ;
          OP_JAL:       nxt = JAL;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: begin
        nxt       = op[5] ? MEMWRITE : MEMREAD;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        nxt     = MEMWB;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_en     = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_en  = 1'b1;
      end
      EXECUTER: begin
        nxt       = ALUWB;
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        nxt       = ALUWB;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: reg_en = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        nxt       = ALUWB;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // Reset already parks state in FETCH; only the enables need an explicit gate.
  assign pc_write  = ~reset & (pc_update | (branch & zero));
  assign ir_write  = ~reset & ir_en;
  assign reg_write = ~reset & reg_en;
  assign mem_write = ~reset & mem_en;
  assign state     = cur;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction's state path and
// per-cycle control outputs are compared against an instruction-level model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected cycle sequence for one instruction, from its class and latency.
  function automatic void path_of(input logic [6:0] o, output int p[$]);
    case (o)
      LW:      p = '{0, 1, 2, 3, 4};
      SW:      p = '{0, 1, 2, 5};
      RT:      p = '{0, 1, 6, 8};
      IT:      p = '{0, 1, 7, 8};
      BR:      p = '{0, 1, 9};
      JL:      p = '{0, 1, 10, 8};
      default: p = '{0, 1};
    endcase
  endfunction

  // ALU function of an arithmetic instruction; only register-form ADD/SUB uses bit 30.
  function automatic logic [2:0] arith_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] expect_ctl(input int st, input logic [6:0] o,
                                             input logic [2:0] f3, input logic f7, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
    logic [1:0] rs = 0, a = 0, b = 0, imm;
    logic [2:0] alu = 3'b000;
    case (st)
      0:  begin irw = 1; pcw = 1; b = 2; rs = 2; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2; alu = arith_fn(o, f3, f7); end
      7:  begin a = 2; b = 1; alu = arith_fn(o, f3, f7); end
      8:  rw = 1;
      9:  begin a = 2; alu = 3'b001; pcw = z; end
      10: begin a = 1; b = 2; pcw = 1; end
      default: ;
    endcase
    imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu};
  endfunction

  // Called just after a falling edge; checks this cycle and advances one cycle.
  task automatic step(input int exp_st, input int zmode);
    zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    #1;
    check("state", 32'(state), 32'(exp_st));
    check($sformatf("ctl st%0d op%07b", exp_st, op),
          32'({pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control}),
          32'(expect_ctl(exp_st, op, funct3, funct7b5, zero)));
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
    int p[$];
    op = o; funct3 = f3; funct7b5 = f7;
    path_of(o, p);
    foreach (p[i]) step(p[i], zmode);
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] o;
    case ($urandom_range(0, 6))
      0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = BR; 5: o = JL;
      default: begin
        o = 7'($urandom);
        if (o == LW || o == SW || o == RT || o == IT || o == BR || o == JL) o = 7'b0000000;
      end
    endcase
    return o;
  endfunction

  initial begin
    reset = 1'b1; op = SW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst state", 32'(state), 32'd0);
    check("rst enables", 32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
    check("rst muxes", 32'({adr_src, alu_src_a, alu_src_b, result_src, alu_control}),
          32'({1'b0, 2'b00, 2'b10, 2'b10, 3'b000}));
    @(negedge clk);
    reset = 1'b0;

    run_instr(LW, 3'b010, 1'b0, 0);
    run_instr(SW, 3'b010, 1'b1, 0);
    run_instr(RT, 3'b000, 1'b1, 0);
    run_instr(RT, 3'b000, 1'b0, 0);
    run_instr(IT, 3'b000, 1'b1, 0);
    run_instr(RT, 3'b010, 1'b0, 0);
    run_instr(RT, 3'b110, 1'b0, 0);
    run_instr(IT, 3'b111, 1'b0, 0);
    run_instr(IT, 3'b001, 1'b1, 0);
    run_instr(BR, 3'b000, 1'b0, 1);
    run_instr(BR, 3'b000, 1'b0, 0);
    run_instr(JL, 3'b000, 1'b0, 0);
    run_instr(7'b0000000, 3'b000, 1'b0, 0);

    // Abandon a store in MEMWRITE with an asynchronous reset pulse.
    op = SW; funct3 = 3'b010; funct7b5 = 1'b0;
    step(0, 0); step(1, 0); step(2, 0);
    #1;
    check("pre-rst state", 32'(state), 32'd5);
    check("pre-rst mem_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rst mem_write", 32'(mem_write), 32'd0);
    check("rst state async", 32'(state), 32'd0);
    check("rst enables mid", 32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
    @(negedge clk);
    #1;
    check("rst held enables", 32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
    check("rst held state", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(SW, 3'b010, 1'b0, 0);

    for (int k = 0; k < 200; k++)
      run_instr(rand_op(), 3'($urandom), 1'($urandom), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
